// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-fetch / data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } arb_src_t;

    localparam int          TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] ARB_ERR_WORD    = 32'hDEADBEEF;

endpackage

// File: rtl/arb_timer.sv
// Counts cycles spent on one memory access; flags the last permitted cycle.
module arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Expiry is only meaningful while an access is in flight.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data memory) for one shared memory port,
// with alternating priority on ties and a per-access timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic [1:0]  state_dbg
);

    // Handshake: if_req/dm_req are level requests held until the matching *_valid;
    // *_valid is a one-cycle strobe and the requester must drop or renew its request
    // in that same cycle. mem_ack is a one-cycle strobe, ignored unless an access is open.

    arb_state_t state;
    arb_src_t   last_served;
    logic       busy;
    logic       expired;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= SRC_IF;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_valid    <= 1'b0;
            if_rdata    <= '0;
            dm_valid    <= 1'b0;
            dm_rdata    <= '0;
            err         <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    // On a tie the side not served last wins.
                    if (dm_req && (!if_req || last_served == SRC_IF)) begin
                        state     <= DM_BUSY;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state     <= IF_BUSY;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack || expired) begin
                        state       <= IDLE;
                        mem_en      <= 1'b0;
                        last_served <= SRC_IF;
                        if_valid    <= 1'b1;
                        if_rdata    <= mem_ack ? mem_rdata : ARB_ERR_WORD;
                        err         <= !mem_ack;
                    end
                end
                DM_BUSY: begin
                    if (mem_ack || expired) begin
                        state       <= IDLE;
                        mem_en      <= 1'b0;
                        mem_we      <= 1'b0;
                        last_served <= SRC_DM;
                        dm_valid    <= 1'b1;
                        err         <= !mem_ack;
                        // Stores leave the previous load data visible.
                        if (!mem_we) begin
                            dm_rdata <= mem_ack ? mem_rdata : ARB_ERR_WORD;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, multi-cycle corner sequences and randomized
// two-requester traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [1:0]  state_dbg;

    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    assign mem_ack   = auto_ack | man_ack;
    assign mem_rdata = man_ack ? man_rdata : auto_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset support ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit snap_if, snap_dm;
    always @(posedge clk) begin
        snap_if = if_req;
        snap_dm = dm_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // ---------------- memory responder + reference model ----------------
    int          next_delay = 0;
    logic [31:0] next_word = '0;
    bit          rand_mode = 1'b0;
    logic [32:0] exp_q[$];      // {err, rdata}
    int          lat_q[$];
    bit          own_q[$];      // 1 = data side
    logic [31:0] grant_log[$];
    bit          m_last_dm, m_busy, en_prev;
    logic [31:0] m_dm_rd, m_word;
    int          m_delay, m_age, m_grant_cyc;

    always @(negedge clk) begin : responder
        logic [32:0] e;
        int          l;
        bit          o;
        bit          win_dm;
        auto_ack = 1'b0;
        if (!rst_n) begin
            m_last_dm = 1'b0;
            m_busy    = 1'b0;
            en_prev   = 1'b0;
            m_dm_rd   = '0;
            exp_q.delete();
            lat_q.delete();
            own_q.delete();
        end else begin
            if (if_valid || dm_valid) begin
                chk("valid_exclusive", 32'(if_valid && dm_valid), 32'd0);
                chk("valid_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    o = own_q.pop_front();
                    chk("valid_owner", 32'(dm_valid), 32'(o));
                    chk("valid_rdata", o ? dm_rdata : if_rdata, e[31:0]);
                    chk("valid_err", 32'(err), 32'(e[32]));
                    chk("valid_latency", cyc - m_grant_cyc, l);
                end
                m_busy = 1'b0;
            end else begin
                chk("err_without_valid", 32'(err), 32'd0);
            end
            if (mem_en && !en_prev) begin
                win_dm = snap_dm && (!snap_if || !m_last_dm);
                chk("grant_addr", mem_addr, win_dm ? dm_addr : if_addr);
                chk("grant_we", 32'(mem_we), win_dm ? 32'(dm_we) : 32'd0);
                chk("grant_wdata", mem_wdata, win_dm ? dm_wdata : 32'd0);
                grant_log.push_back(mem_addr);
                if (rand_mode) m_delay = int'($urandom_range(0, TO + 2));
                else m_delay = next_delay;
                m_word      = rand_mode ? hash(mem_addr) : next_word;
                m_age       = 0;
                m_busy      = 1'b1;
                m_grant_cyc = cyc;
                m_last_dm   = win_dm;
                if (m_delay <= TO - 1) begin
                    e = {1'b0, m_word};
                    l = m_delay + 1;
                end else begin
                    e = {1'b1, ARB_ERR_WORD};
                    l = TO;
                end
                if (win_dm && dm_we) e[31:0] = m_dm_rd;
                else if (win_dm) m_dm_rd = e[31:0];
                exp_q.push_back(e);
                lat_q.push_back(l);
                own_q.push_back(win_dm);
            end
            en_prev = mem_en;
            if (m_busy) begin
                if (m_age == m_delay) begin
                    auto_ack   = 1'b1;
                    auto_rdata = m_word;
                end
                m_age++;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          delay;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] g_addr = '0, g_wdata = '0, rd = '0;
        logic        g_we = 1'b0, e = 1'b0, ov = 1'b0;
        int          g_cyc = 0, v_cyc = 0;
        bit          got_g = 1'b0, got_v = 1'b0;
        @(negedge clk);
        #1;
        next_delay = v.delay;
        next_word  = v.word;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int k = 0; k < 40 && !got_v; k++) begin
            @(negedge clk);
            if (mem_en && !got_g) begin
                got_g = 1'b1; g_cyc = cyc; g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
            end
            if (if_valid || dm_valid) begin
                got_v = 1'b1; v_cyc = cyc; e = err;
                rd = v.is_dm ? dm_rdata : if_rdata;
                ov = v.is_dm ? dm_valid : if_valid;
            end
        end
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        chk($sformatf("vec%0d_done", idx), 32'(got_v), 32'd1);
        chk($sformatf("vec%0d_addr", idx), g_addr, v.addr);
        chk($sformatf("vec%0d_we", idx), 32'(g_we), 32'(v.is_dm && v.we));
        chk($sformatf("vec%0d_wdata", idx), g_wdata, v.is_dm ? v.wdata : 32'd0);
        chk($sformatf("vec%0d_owner", idx), 32'(ov), 32'd1);
        chk($sformatf("vec%0d_rdata", idx), rd, v.exp_rdata);
        chk($sformatf("vec%0d_err", idx), 32'(e), 32'(v.exp_err));
        chk($sformatf("vec%0d_latency", idx), v_cyc - g_cyc, v.exp_lat);
    endtask

    // ---------------- random requesters ----------------
    task automatic if_driver(input int n);
        bit done;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            if_addr = 32'h0000_1000 | (32'($urandom_range(0, 255)) << 2);
            if_req  = 1'b1;
            done    = 1'b0;
            for (int k = 0; k < 80 && !done; k++) begin
                @(negedge clk);
                done = if_valid;
            end
            chk("if_wait", 32'(done), 32'd1);
            #1 if_req = 1'b0;
        end
    endtask

    task automatic dm_driver(input int n);
        bit done;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            dm_addr  = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
            dm_we    = 1'($urandom_range(0, 1));
            dm_wdata = $urandom;
            dm_req   = 1'b1;
            done     = 1'b0;
            for (int k = 0; k < 80 && !done; k++) begin
                @(negedge clk);
                done = dm_valid;
            end
            chk("dm_wait", 32'(done), 32'd1);
            #1 dm_req = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] alt_exp [4];
        int          nvalid;
        bit          seen;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h20080005, 3,  32'h20080005, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h11223344, 0,  32'h11223344, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h99999999, 2,  32'h11223344, 1'b0, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h55555555, 99, 32'hDEADBEEF, 1'b1, 16};
        vecs[4] = '{1'b1, 1'b1, 32'h104, 32'h01020304, 32'h66666666, 99, 32'hDEADBEEF, 1'b1, 16};
        vecs[5] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'hCAFEF00D, 15, 32'hCAFEF00D, 1'b0, 16};
        vecs[6] = '{1'b0, 1'b0, 32'h48,  32'h0,        32'h77777777, 16, 32'hDEADBEEF, 1'b1, 16};
        vecs[7] = '{1'b1, 1'b0, 32'h204, 32'h0,        32'h0BADC0DE, 15, 32'h0BADC0DE, 1'b0, 16};
        alt_exp = '{32'h100, 32'h40, 32'h100, 32'h40};

        // Both requesters pending straight out of reset.
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hA5A5A5A5;
        next_delay = 1;
        next_word  = 32'h0000_1111;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        grant_log.delete();
        #1 rst_n = 1'b1;

        nvalid = 0;
        seen   = 1'b0;
        for (int k = 0; k < 60 && nvalid < 4; k++) begin
            @(negedge clk);
            if (mem_en && !seen) begin
                seen = 1'b1;
                chk("tie_first_addr", mem_addr, 32'h100);
                chk("tie_first_we", 32'(mem_we), 32'd1);
                chk("tie_first_wdata", mem_wdata, 32'hA5A5A5A5);
            end
            if (if_valid || dm_valid) nvalid++;
        end
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("alt_completions", nvalid, 4);
        chk("alt_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("alt_order%0d", i), grant_log[i], alt_exp[i]);
        end
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of a fetch, then a stray ack while idle.
        @(negedge clk);
        #1;
        next_delay = 8;
        next_word  = 32'h0F0F0F0F;
        if_req     = 1'b1;
        if_addr    = 32'h80;
        for (int k = 0; k < 10 && mem_en !== 1'b1; k++) @(negedge clk);
        chk("rstmid_grant", 32'(mem_en), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_en", 32'(mem_en), 32'd0);
        chk("rstmid_state", 32'(state_dbg), 32'(IDLE));
        chk("rstmid_if_valid", 32'(if_valid), 32'd0);
        #1;
        rst_n     = 1'b1;
        man_ack   = 1'b1;
        man_rdata = 32'h12345678;
        @(negedge clk);
        #1 man_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ack_if_valid", 32'(if_valid), 32'd0);
            chk("idle_ack_dm_valid", 32'(dm_valid), 32'd0);
            chk("idle_ack_err", 32'(err), 32'd0);
            chk("idle_ack_mem_en", 32'(mem_en), 32'd0);
            chk("idle_ack_state", 32'(state_dbg), 32'(IDLE));
            chk("idle_ack_if_rdata", if_rdata, 32'd0);
            chk("idle_ack_mem_addr", mem_addr, 32'd0);
        end

        // Randomized concurrent traffic.
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        rand_mode = 1'b1;
        fork
            if_driver(25);
            dm_driver(25);
        join
        repeat (3) @(negedge clk);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: cycles waited for mem_ack before an access is abandoned.
REQ-002 The block SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port if_req  in  1  instruction-fetch request, held until if_valid.
REQ-005 The block SHALL have port if_addr  in  32  fetch address.
REQ-006 The block SHALL have ports if_valid  out  1 and if_rdata  out  32: a one-cycle completion pulse and the fetched word.
REQ-007 The block SHALL have port dm_req  in  1  data-memory request (LW/SW), held until dm_valid.
REQ-008 The block SHALL have ports dm_we  in  1, dm_addr  in  32 and dm_wdata  in  32: write enable, address and store data.
REQ-009 The block SHALL have ports dm_valid  out  1 and dm_rdata  out  32: a one-cycle completion pulse and the load data.
REQ-010 The block SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  32 and mem_wdata  out  32, all driving the single shared memory port.
REQ-011 The block SHALL have ports mem_rdata  in  32 and mem_ack  in  1: read data, and a one-cycle pulse when the memory completes.
REQ-012 The block SHALL have port err  out  1  one-cycle pulse when an access times out.

Function
REQ-013 State machine: IDLE, IF_BUSY and DM_BUSY; no other states SHALL be reachable.
REQ-014 In IDLE with one request pending, the FSM SHALL go to that requester's BUSY state on the next edge.
REQ-015 When both requests are pending in IDLE, the winner SHALL be the requester not served last; last_served resets to IF, so DM wins the first tie.
REQ-016 On grant, the address, we and wdata SHALL be latched into registers; mem_* outputs are driven only from these registers.
REQ-017 mem_en SHALL be 1 throughout IF_BUSY and DM_BUSY and 0 in IDLE; mem_we SHALL be 1 only in DM_BUSY with latched we=1.
REQ-018 In IF_BUSY, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-019 On mem_ack in a BUSY state, the FSM SHALL capture mem_rdata into that requester's rdata register (reads only), pulse its valid on the next cycle, update last_served, and return to IDLE.
REQ-020 Latency: request seen in IDLE at cycle N -> mem_en=1 at N+1; mem_ack at cycle M -> valid=1 at M+1; a new grant is possible at M+2 at the earliest.
REQ-021 On a write completion, dm_rdata SHALL hold its previous value.
REQ-022 A cycle counter SHALL clear on grant and increment each BUSY cycle.
REQ-023 If the counter reaches TIMEOUT-1 without mem_ack, the block SHALL pulse err and the requester's valid together, load rdata with 32'hDEADBEEF (reads), and return to IDLE.
REQ-024 If mem_ack and the timeout fall in the same cycle, mem_ack SHALL win and err SHALL stay 0.
REQ-025 Request deassertion during BUSY SHALL be ignored; the latched access completes.
REQ-026 mem_ack in IDLE SHALL be ignored and SHALL NOT change state or outputs.
REQ-027 if_valid and dm_valid SHALL never be 1 in the same cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE, abandon any access in flight without a valid or err pulse, and zero all outputs, rdata registers and the counter.
REQ-029 While rst_n=0 at a clock edge, last_served SHALL be set to IF.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enumeration, the TIMEOUT default and the constant ARB_ERR_WORD = 32'hDEADBEEF.
REQ-031 The timeout counter SHALL be one sub-module, arb_timer (inputs clear and enable; output expired), instantiated once.

Verification
REQ-032 Bench: if_req, if_addr=0x40, mem_ack 3 cycles after mem_en with mem_rdata=0x20080005 -> mem_addr=0x40 and mem_we=0; if_valid pulses once with if_rdata=0x20080005.
REQ-033 Bench: if_req and dm_req (we=1, addr=0x100, wdata=0xA5A5A5A5) both asserted from reset -> DM served first with mem_we=1 and mem_wdata=0xA5A5A5A5; then IF is served.
REQ-034 Bench: both requests held continuously across 4 completions -> grants alternate DM, IF, DM, IF.
REQ-035 Bench: dm_req read, mem_ack never asserted, TIMEOUT=16 -> err and dm_valid pulse together 16 cycles after grant with dm_rdata=0xDEADBEEF.
REQ-036 Bench: rst_n=0 for one cycle during IF_BUSY, then mem_ack -> no if_valid, mem_en=0 after the edge, FSM in IDLE.
REQ-037 Bench: mem_ack arriving in the timeout cycle -> normal valid with mem_rdata and err=0.
